// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: two-stage issue/writeback front end for an external combinational ALU.
// Decodes RV64I integer ops (OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC) into a 4-bit ALU
// code, registers operands in E (which drives the ALU), and registers the final result in W.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc, in_rd
//                                      decoded instruction input (valid/ready)
//   alu_a, alu_b, alu_op               ALU request (from E registers)
//   alu_result, alu_zero, alu_overflow ALU response (combinational)
//   out_valid/out_ready, out_result, out_zero, out_overflow, out_illegal, out_rd
//                                      registered writeback output (valid/ready)
module riscv_alu_issue #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic [4:0]      in_rd,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic            alu_overflow,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_zero,
   output logic            out_overflow,
   output logic            out_illegal,
   output logic [4:0]      out_rd
);

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB  = 4'b0001, OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_SLT = 4'b0011, OP_SLTU = 4'b0100, OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110, OP_SRA  = 4'b0111, OP_OR    = 4'b1000;
   localparam logic [3:0] OP_AND = 4'b1001, OP_LUI  = 4'b1010, OP_AUIPC = 4'b1011;

   localparam logic [6:0] OPC_OP    = 7'b0110011, OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP32  = 7'b0111011, OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111, OPC_AUIPC   = 7'b0010111;

   // ---------------- decode ----------------
   logic [XLEN-1:0] src, dec_a, dec_b, rs1_sext, rs1_zext, src_sext;
   logic [3:0]      dec_op;
   logic            dec_word, dec_wshift, dec_illegal;
   logic            f7_zero, f7_alt, is_reg;

   always_comb begin
      is_reg   = (in_opcode == OPC_OP) || (in_opcode == OPC_OP32);
      src      = is_reg ? in_rs2 : in_imm;
      f7_zero  = (in_funct7 == 7'b0000000);
      f7_alt   = (in_funct7 == 7'b0100000);
      rs1_sext = {{(XLEN-32){in_rs1[31]}}, in_rs1[31:0]};
      rs1_zext = {{(XLEN-32){1'b0}}, in_rs1[31:0]};
      src_sext = {{(XLEN-32){src[31]}}, src[31:0]};

      dec_op      = OP_ADD;
      dec_a       = in_rs1;
      dec_b       = src;
      dec_word    = 1'b0;
      dec_wshift  = 1'b0;
      dec_illegal = 1'b0;

      case (in_opcode)
         OPC_OP, OPC_OPIMM: begin
            case (in_funct3)
               3'b000: dec_op = OP_ADD;
               3'b001: dec_op = OP_SLL;
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: dec_op = OP_SRL;
               3'b110: dec_op = OP_OR;
               default: dec_op = OP_AND;
            endcase
            if (in_opcode == OPC_OP) begin
               if (f7_alt && in_funct3 == 3'b000) dec_op = OP_SUB;
               else if (f7_alt && in_funct3 == 3'b101) dec_op = OP_SRA;
               else if (!f7_zero) dec_illegal = 1'b1;
            end else begin
               // Immediate form: funct7 is immediate bits except for shifts, where
               // funct7[0] is shamt[5] and funct7[6:1] selects the shift kind.
               if (in_funct3 == 3'b001 && in_funct7[6:1] != 6'b000000) dec_illegal = 1'b1;
               if (in_funct3 == 3'b101) begin
                  if (in_funct7[6:1] == 6'b010000) dec_op = OP_SRA;
                  else if (in_funct7[6:1] != 6'b000000) dec_illegal = 1'b1;
               end
            end
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101) dec_b = {{(XLEN-6){1'b0}}, src[5:0]};
         end
         OPC_OP32, OPC_OPIMM32: begin
            dec_word = 1'b1;
            case (in_funct3)
               3'b000: begin
                  dec_a = rs1_sext;
                  dec_b = src_sext;
                  if (in_opcode == OPC_OP32) begin
                     if (f7_alt) dec_op = OP_SUB;
                     else if (!f7_zero) dec_illegal = 1'b1;
                  end
               end
               3'b001: begin
                  dec_op      = OP_SLL;
                  dec_wshift  = 1'b1;
                  dec_b       = {{(XLEN-5){1'b0}}, src[4:0]};
                  dec_illegal = !f7_zero;
               end
               3'b101: begin
                  dec_wshift  = 1'b1;
                  dec_b       = {{(XLEN-5){1'b0}}, src[4:0]};
                  dec_op      = f7_alt ? OP_SRA : OP_SRL;
                  dec_a       = f7_alt ? rs1_sext : rs1_zext;
                  dec_illegal = !(f7_zero || f7_alt);
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_op = OP_LUI;
            dec_a  = '0;
            dec_b  = in_imm;
         end
         OPC_AUIPC: begin
            dec_op = OP_AUIPC;
            dec_a  = in_pc;
            dec_b  = in_imm;
         end
         default: dec_illegal = 1'b1;
      endcase

      // Illegal instructions still flow through as a harmless ADD 0,0.
      if (dec_illegal) begin
         dec_op     = OP_ADD;
         dec_a      = '0;
         dec_b      = '0;
         dec_word   = 1'b0;
         dec_wshift = 1'b0;
      end
   end

   // ---------------- handshake ----------------
   logic e_valid_q, e_valid_d, w_valid_q, w_valid_d, w_adv, in_fire, e_xfer;

   assign w_adv    = !w_valid_q || out_ready;
   assign in_ready = !e_valid_q || w_adv;
   assign in_fire  = in_valid && in_ready;
   assign e_xfer   = e_valid_q && w_adv;

   // ---------------- E stage ----------------
   logic [XLEN-1:0] e_a_q, e_a_d, e_b_q, e_b_d;
   logic [3:0]      e_op_q, e_op_d;
   logic [4:0]      e_rd_q, e_rd_d;
   logic            e_word_q, e_word_d, e_wshift_q, e_wshift_d, e_illegal_q, e_illegal_d;

   always_comb begin
      e_valid_d   = e_valid_q;
      e_a_d       = e_a_q;
      e_b_d       = e_b_q;
      e_op_d      = e_op_q;
      e_rd_d      = e_rd_q;
      e_word_d    = e_word_q;
      e_wshift_d  = e_wshift_q;
      e_illegal_d = e_illegal_q;
      if (in_fire) begin
         e_valid_d   = 1'b1;
         e_a_d       = dec_a;
         e_b_d       = dec_b;
         e_op_d      = dec_op;
         e_rd_d      = in_rd;
         e_word_d    = dec_word;
         e_wshift_d  = dec_wshift;
         e_illegal_d = dec_illegal;
      end else if (e_xfer) begin
         e_valid_d = 1'b0;
      end
   end

   assign alu_a  = e_a_q;
   assign alu_b  = e_b_q;
   assign alu_op = e_op_q;

   // ---------------- W stage ----------------
   logic [XLEN-1:0] fin_result, word_result, w_result_q, w_result_d;
   logic            fin_zero, fin_ov;
   logic            w_zero_q, w_zero_d, w_ov_q, w_ov_d, w_illegal_q, w_illegal_d;
   logic [4:0]      w_rd_q, w_rd_d;

   assign word_result = {{(XLEN-32){alu_result[31]}}, alu_result[31:0]};

   always_comb begin
      fin_result = alu_result;
      fin_ov     = alu_overflow;
      fin_zero   = alu_zero;
      if (e_illegal_q) begin
         fin_result = '0;
         fin_ov     = 1'b0;
         fin_zero   = 1'b0;
      end else if (e_word_q) begin
         // Zero is taken after sign extension; alu_zero sees all 64 bits.
         fin_result = word_result;
         fin_ov     = e_wshift_q ? 1'b0 : (alu_result[32] ^ alu_result[31]);
         fin_zero   = (word_result == '0);
      end
   end

   always_comb begin
      w_valid_d   = w_adv ? e_valid_q : w_valid_q;
      w_result_d  = w_result_q;
      w_zero_d    = w_zero_q;
      w_ov_d      = w_ov_q;
      w_illegal_d = w_illegal_q;
      w_rd_d      = w_rd_q;
      if (e_xfer) begin
         w_result_d  = fin_result;
         w_zero_d    = fin_zero;
         w_ov_d      = fin_ov;
         w_illegal_d = e_illegal_q;
         w_rd_d      = e_rd_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_q   <= 1'b0;
         e_a_q       <= '0;
         e_b_q       <= '0;
         e_op_q      <= OP_ADD;
         e_rd_q      <= '0;
         e_word_q    <= 1'b0;
         e_wshift_q  <= 1'b0;
         e_illegal_q <= 1'b0;
         w_valid_q   <= 1'b0;
         w_result_q  <= '0;
         w_zero_q    <= 1'b0;
         w_ov_q      <= 1'b0;
         w_illegal_q <= 1'b0;
         w_rd_q      <= '0;
      end else begin
         e_valid_q   <= e_valid_d;
         e_a_q       <= e_a_d;
         e_b_q       <= e_b_d;
         e_op_q      <= e_op_d;
         e_rd_q      <= e_rd_d;
         e_word_q    <= e_word_d;
         e_wshift_q  <= e_wshift_d;
         e_illegal_q <= e_illegal_d;
         w_valid_q   <= w_valid_d;
         w_result_q  <= w_result_d;
         w_zero_q    <= w_zero_d;
         w_ov_q      <= w_ov_d;
         w_illegal_q <= w_illegal_d;
         w_rd_q      <= w_rd_d;
      end
   end

   assign out_valid    = w_valid_q;
   assign out_result   = w_result_q;
   assign out_zero     = w_zero_q;
   assign out_overflow = w_ov_q;
   assign out_illegal  = w_illegal_q;
   assign out_rd       = w_rd_q;

endmodule
